// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU
// selects, step-state encoding and instruction-class helpers.
package cpu_ctrl_pkg;

  localparam int OPW  = 5;
  localparam int NREG = 16;

  // Opcodes (IR[31:27])
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_AND  = 5'b01001;
  localparam logic [OPW-1:0] OP_OR   = 5'b01010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // ALU function selects share the encoding of the matching R-type opcode
  localparam logic [OPW-1:0] ALU_NONE = 5'b00000;
  localparam logic [OPW-1:0] ALU_ADD  = OP_ADD;
  localparam logic [OPW-1:0] ALU_AND  = OP_AND;
  localparam logic [OPW-1:0] ALU_OR   = OP_OR;

  // Step states; T0..T7 are contiguous so "at or past the last step" is a compare
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } step_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_IMM,
    CLS_MULDIV,
    CLS_LD,
    CLS_ST,
    CLS_HALT
  } op_class_e;

  function automatic op_class_e classify(input logic [OPW-1:0] op);
    case (op)
      OP_LD:                          return CLS_LD;
      OP_ST:                          return CLS_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       return CLS_IMM;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_HALT:                        return CLS_HALT;
      OP_NOP:                         return CLS_NONE;
      default:                        return CLS_NONE;
    endcase
  endfunction

  // Final step of each class; classes without execute steps end at T2
  function automatic step_e last_step(input op_class_e c);
    case (c)
      CLS_RTYPE, CLS_IMM: return ST_T5;
      CLS_MULDIV:         return ST_T6;
      CLS_LD, CLS_ST:     return ST_T7;
      default:            return ST_T2;
    endcase
  endfunction

  function automatic logic [OPW-1:0] imm_alu(input logic [OPW-1:0] op);
    case (op)
      OP_ADDI: return ALU_ADD;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [31:0]      ir;
  logic             stop;
  logic [NREG-1:0]  r_in;
  logic [NREG-1:0]  r_out;
  logic             pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, c_out, ba_out;
  logic             pc_in, mar_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
  logic             inc_pc, read, write;
  logic [OPW-1:0]   alu_op;
  logic             run;

  modport master (
    input  ir, stop,
    output r_in, r_out,
    output pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, c_out, ba_out,
    output pc_in, mar_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in,
    output inc_pc, read, write, alu_op, run
  );

  modport slave (
    output ir, stop,
    input  r_in, r_out,
    input  pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, c_out, ba_out,
    input  pc_in, mar_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in,
    input  inc_pc, read, write, alu_op, run
  );
endinterface

// File: rtl/reg_select_encode.sv
// Turns the IR register fields plus the sequencer's field-select strobes
// into one-hot register load/drive vectors (all-zero when not requested).
module reg_select_encode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rc,
  input  logic            gra,
  input  logic            grb,
  input  logic            grc,
  input  logic            rin,
  input  logic            rout,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out
);

  logic [3:0] sel;

  // The sequencer asserts at most one of gra/grb/grc, so OR-merging is safe
  assign sel = ({4{gra}} & ra) | ({4{grb}} & rb) | ({4{grc}} & rc);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      assign r_in[gi]  = rin  & (sel == 4'(gi));
      assign r_out[gi] = rout & (sel == 4'(gi));
    end
  endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch (T0-T2) and execute (T3-T7), decodes
// the IR and drives every datapath strobe as a Moore decode of the step.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  step_e           state_q, state_d;
  op_class_e       cls;
  logic [OPW-1:0]  op;
  logic [3:0]      ra, rb, rc;
  logic            done;
  logic            gra, grb, grc, rin, rout;
  logic [NREG-1:0] r_in_w, r_out_w;
  logic            unused_imm;

  assign op  = bus.ir[31:27];
  assign ra  = bus.ir[26:23];
  assign rb  = bus.ir[22:19];
  assign rc  = bus.ir[18:15];
  assign cls = classify(op);

  // The constant field is consumed by the datapath, not by control
  assign unused_imm = ^bus.ir[14:0];

  // Step register; clear forces RST immediately so all strobes drop at once
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= ST_RST;
    else        state_q <= state_d;
  end

  // Next step: advance one step per clock, return to T0 after the class's
  // last step, and divert any T0 entry to HALT while stop is high
  always_comb begin
    state_d = state_q;
    done    = (state_q >= last_step(cls));
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = (cls == CLS_HALT) ? ST_HALT : (done ? ST_T0 : ST_T3);
      ST_T3:   state_d = done ? ST_T0 : ST_T4;
      ST_T4:   state_d = done ? ST_T0 : ST_T5;
      ST_T5:   state_d = done ? ST_T0 : ST_T6;
      ST_T6:   state_d = done ? ST_T0 : ST_T7;
      ST_T7:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
    if (state_d == ST_T0 && bus.stop) state_d = ST_HALT;
  end

  // Strobe decode from the current step and instruction class
  always_comb begin
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
    bus.pc_out = 1'b0; bus.zlow_out = 1'b0; bus.zhigh_out = 1'b0; bus.mdr_out = 1'b0;
    bus.hi_out = 1'b0; bus.lo_out = 1'b0; bus.c_out = 1'b0; bus.ba_out = 1'b0;
    bus.pc_in = 1'b0; bus.mar_in = 1'b0; bus.mdr_in = 1'b0; bus.ir_in = 1'b0;
    bus.y_in = 1'b0; bus.zlow_in = 1'b0; bus.zhigh_in = 1'b0; bus.hi_in = 1'b0;
    bus.lo_in = 1'b0; bus.inc_pc = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.alu_op = ALU_NONE;
    bus.run    = (state_q != ST_RST) && (state_q != ST_HALT);

    case (state_q)
      ST_T0: begin
        bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; bus.zlow_in = 1'b1;
      end
      ST_T1: begin
        bus.zlow_out = 1'b1; bus.pc_in = 1'b1; bus.read = 1'b1; bus.mdr_in = 1'b1;
      end
      ST_T2: begin
        bus.mdr_out = 1'b1; bus.ir_in = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin grb = 1'b1; rout = 1'b1; bus.y_in = 1'b1; end
          CLS_MULDIV:         begin gra = 1'b1; rout = 1'b1; bus.y_in = 1'b1; end
          CLS_LD, CLS_ST: begin
            grb = 1'b1; rout = 1'b1; bus.ba_out = 1'b1; bus.y_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_RTYPE: begin
            grc = 1'b1; rout = 1'b1; bus.alu_op = op; bus.zlow_in = 1'b1;
          end
          CLS_IMM: begin
            bus.c_out = 1'b1; bus.alu_op = imm_alu(op); bus.zlow_in = 1'b1;
          end
          CLS_MULDIV: begin
            grb = 1'b1; rout = 1'b1; bus.alu_op = op;
            bus.zlow_in = 1'b1; bus.zhigh_in = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            bus.c_out = 1'b1; bus.alu_op = ALU_ADD; bus.zlow_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin bus.zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; end
          CLS_MULDIV:         begin bus.zlow_out = 1'b1; bus.lo_in = 1'b1; end
          CLS_LD, CLS_ST:     begin bus.zlow_out = 1'b1; bus.mar_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_MULDIV: begin bus.zhigh_out = 1'b1; bus.hi_in = 1'b1; end
          CLS_LD:     begin bus.read = 1'b1; bus.mdr_in = 1'b1; end
          CLS_ST:     begin gra = 1'b1; rout = 1'b1; bus.mdr_in = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD:  begin bus.mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
          CLS_ST:  bus.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  reg_select_encode u_reg_sel (
    .ra    (ra),
    .rb    (rb),
    .rc    (rc),
    .gra   (gra),
    .grb   (grb),
    .grc   (grc),
    .rin   (rin),
    .rout  (rout),
    .r_in  (r_in_w),
    .r_out (r_out_w)
  );

  assign bus.r_in  = r_in_w;
  assign bus.r_out = r_out_w;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded into the list of
// per-cycle strobe sets from the step table, then compared cycle by cycle.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  // Strobe bit positions in the observation vector
  localparam logic [19:0] S_PC_OUT    = 20'h00001;
  localparam logic [19:0] S_ZLOW_OUT  = 20'h00002;
  localparam logic [19:0] S_ZHIGH_OUT = 20'h00004;
  localparam logic [19:0] S_MDR_OUT   = 20'h00008;
  localparam logic [19:0] S_HI_OUT    = 20'h00010;
  localparam logic [19:0] S_LO_OUT    = 20'h00020;
  localparam logic [19:0] S_C_OUT     = 20'h00040;
  localparam logic [19:0] S_BA_OUT    = 20'h00080;
  localparam logic [19:0] S_PC_IN     = 20'h00100;
  localparam logic [19:0] S_MAR_IN    = 20'h00200;
  localparam logic [19:0] S_MDR_IN    = 20'h00400;
  localparam logic [19:0] S_IR_IN     = 20'h00800;
  localparam logic [19:0] S_Y_IN      = 20'h01000;
  localparam logic [19:0] S_ZLOW_IN   = 20'h02000;
  localparam logic [19:0] S_ZHIGH_IN  = 20'h04000;
  localparam logic [19:0] S_HI_IN     = 20'h08000;
  localparam logic [19:0] S_LO_IN     = 20'h10000;
  localparam logic [19:0] S_INC_PC    = 20'h20000;
  localparam logic [19:0] S_READ      = 20'h40000;
  localparam logic [19:0] S_WRITE     = 20'h80000;

  localparam logic [57:0] ALL_ZERO = 58'h0;

  logic [4:0] op_tbl [17] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                              5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                              5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111,
                              5'b11010, 5'b11011};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [57:0] exp_q[$];
  bit          exp_halt;

  function automatic logic [57:0] observe();
    return {bus.r_in, bus.r_out, bus.alu_op, bus.run,
            bus.write, bus.read, bus.inc_pc, bus.lo_in, bus.hi_in, bus.zhigh_in,
            bus.zlow_in, bus.y_in, bus.ir_in, bus.mdr_in, bus.mar_in, bus.pc_in,
            bus.ba_out, bus.c_out, bus.lo_out, bus.hi_out, bus.mdr_out,
            bus.zhigh_out, bus.zlow_out, bus.pc_out};
  endfunction

  function automatic logic [57:0] v(input logic [15:0] rin, input logic [15:0] rout,
                                    input logic [4:0] alu, input logic [19:0] s);
    return {rin, rout, alu, 1'b1, s};
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] i);
    return 16'h0001 << i;
  endfunction

  task automatic check_eq(input string tag, input logic [57:0] obs, input logic [57:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the cycle-by-cycle strobe list an instruction must produce
  task automatic build_expected(input logic [31:0] w);
    int         op;
    logic [3:0] ra, rb, rc;
    logic [4:0] alu;
    op = int'(w[31:27]);
    ra = w[26:23]; rb = w[22:19]; rc = w[18:15];
    exp_q.delete();
    exp_halt = (op == 27);
    exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_PC_OUT | S_MAR_IN | S_INC_PC | S_ZLOW_IN));
    exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_ZLOW_OUT | S_PC_IN | S_READ | S_MDR_IN));
    exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_MDR_OUT | S_IR_IN));
    if (op >= 3 && op <= 10) begin
      exp_q.push_back(v(16'h0, oh(rb), 5'd0, S_Y_IN));
      exp_q.push_back(v(16'h0, oh(rc), w[31:27], S_ZLOW_IN));
      exp_q.push_back(v(oh(ra), 16'h0, 5'd0, S_ZLOW_OUT));
    end else if (op >= 11 && op <= 13) begin
      alu = (op == 11) ? 5'd3 : (op == 12) ? 5'd9 : 5'd10;
      exp_q.push_back(v(16'h0, oh(rb), 5'd0, S_Y_IN));
      exp_q.push_back(v(16'h0, 16'h0, alu, S_C_OUT | S_ZLOW_IN));
      exp_q.push_back(v(oh(ra), 16'h0, 5'd0, S_ZLOW_OUT));
    end else if (op == 14 || op == 15) begin
      exp_q.push_back(v(16'h0, oh(ra), 5'd0, S_Y_IN));
      exp_q.push_back(v(16'h0, oh(rb), w[31:27], S_ZLOW_IN | S_ZHIGH_IN));
      exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_ZLOW_OUT | S_LO_IN));
      exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_ZHIGH_OUT | S_HI_IN));
    end else if (op == 0 || op == 2) begin
      exp_q.push_back(v(16'h0, oh(rb), 5'd0, S_BA_OUT | S_Y_IN));
      exp_q.push_back(v(16'h0, 16'h0, 5'd3, S_C_OUT | S_ZLOW_IN));
      exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_ZLOW_OUT | S_MAR_IN));
      if (op == 0) begin
        exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_READ | S_MDR_IN));
        exp_q.push_back(v(oh(ra), 16'h0, 5'd0, S_MDR_OUT));
      end else begin
        exp_q.push_back(v(16'h0, oh(ra), 5'd0, S_MDR_IN));
        exp_q.push_back(v(16'h0, 16'h0, 5'd0, S_WRITE));
      end
    end
  endtask

  // Entered at a falling edge with the DUT in T0; leaves at a falling edge
  // with the DUT in T0 again (after a HALT or abort, via a clear pulse).
  task automatic run_instr(input logic [31:0] w, input bit stop_end,
                           input int abort_at, input string name);
    int n;
    bit halted;
    build_expected(w);
    n = exp_q.size();
    halted = exp_halt || stop_end;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clock);
      bus.ir   = w;
      // stop only matters when the next step would be T0; toggle it elsewhere
      bus.stop = (k == n - 1 && !exp_halt) ? stop_end : 1'($urandom_range(0, 1));
      #1;
      check_eq($sformatf("%s_step%0d", name, k), observe(), exp_q[k]);
      if (k == abort_at) begin
        #2;
        bus.stop = 1'b0;
        clear = 1'b0;
        #1;
        check_eq({name, "_async_clear"}, observe(), ALL_ZERO);
        @(negedge clock);
        #1;
        check_eq({name, "_clear_held"}, observe(), ALL_ZERO);
        clear = 1'b1;
        @(negedge clock);
        $display("txn %s ir=%h aborted at step %0d", name, w, k);
        return;
      end
    end
    @(negedge clock);
    bus.stop = 1'b0;
    if (halted) begin
      for (int c = 0; c < 10; c++) begin
        if (c > 0) @(negedge clock);
        #1;
        check_eq($sformatf("%s_halt%0d", name, c), observe(), ALL_ZERO);
      end
      clear = 1'b0;
      #1;
      check_eq({name, "_halt_clear"}, observe(), ALL_ZERO);
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
    end
    $display("txn %s ir=%h steps=%0d halted=%0d", name, w, n, halted);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int unsigned r;
    clear    = 1'b0;
    bus.ir   = 32'h0;
    bus.stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      check_eq($sformatf("reset_hold%0d", c), observe(), ALL_ZERO);
    end
    clear = 1'b1;
    @(negedge clock);

    run_instr(32'h43320000, 1'b0, -1, "rol_r6_r6_r4");
    run_instr(32'h71880000, 1'b0, -1, "mul_r3_r1");
    run_instr(32'h01000055, 1'b0, -1, "ld_r2_55_r0");
    run_instr(32'hD8000000, 1'b0, -1, "halt");
    run_instr({5'b00011, 4'd5, 4'd9, 4'd12, 15'h0}, 1'b0, 4, "add_abort_t4");
    run_instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'h0}, 1'b1, -1, "add_stop_t5");
    run_instr({5'b11010, 27'h0}, 1'b1, -1, "nop_stop_t2");

    for (int i = 0; i < 200; i++) begin
      w = $urandom;
      r = $urandom_range(0, 19);
      if (r < 17) w[31:27] = op_tbl[r];
      run_instr(w, ($urandom_range(0, 7) == 0), -1, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
